// File: rtl/lsl_iterative_if.sv
// lsl_iterative_if: operand/result valid-ready bundle for the iterative
// logical shift-left unit. The master drives operands and result-ready;
// the slave (the shifter) drives operand-ready and the result.
interface lsl_iterative_if #(
    parameter int WIDTH = 64
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_shamt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lsl_iterative.sv
// lsl_iterative: multi-cycle logical shift-left. One power-of-two stage is
// applied per clock (stage i shifts by 2**i when shamt[i] is set), so a
// result appears SHW edges after the operand is accepted.
// Optional build macro LSL_EARLY_EXIT_EN: leave SHIFT as soon as no higher
// shift-amount bits remain set; results are unchanged, latency shrinks.
module lsl_iterative #(
    parameter int WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    lsl_iterative_if.slave    bus,
    output logic              busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW:0]     stage_amt;
    logic             last_stage;

`ifdef LSL_EARLY_EXIT_EN
    logic [SHW-1:0]   upper_bits;

    // Final stage: counter at the top bit, or no shift bits left above cnt
    always_comb begin
        upper_bits = (shamt_q >> cnt_q) >> 1;
        last_stage = (cnt_q == SHW'(SHW - 1)) || (upper_bits == '0);
    end
`else
    // Final stage: counter has reached the most significant shift bit
    always_comb begin
        last_stage = (cnt_q == SHW'(SHW - 1));
    end
`endif

    // Next-state, stage counter and data-path update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shamt_d   = shamt_q;
        data_d    = data_q;
        stage_amt = (SHW + 1)'(1) << cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    shamt_d = bus.in_shamt;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shamt_q[cnt_q]) begin
                    data_d = data_q << stage_amt;
                end
                cnt_d = cnt_q + 1'b1;
                if (last_stage) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and data registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shamt_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shamt_q <= shamt_d;
            data_q  <= data_d;
        end
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = data_q;
        busy          = (state_q == SHIFT) || (state_q == DONE);
    end

    // Result held steady while the consumer stalls
    a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(data_q)));

    // Operand ready is exactly the idle state
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        bus.in_ready == (state_q == IDLE));

    // Unused encoding returns to idle on the next edge
    a_recover: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == 2'd3) |=> (state_q == IDLE));

endmodule

// File: tb/tb_lsl_iterative.sv
// tb_lsl_iterative: directed bench for lsl_iterative at WIDTH=16 with a
// transaction-level reference model checked every cycle on the falling edge.
`timescale 1ns/1ps
module tb_lsl_iterative;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;
`ifdef LSL_EARLY_EXIT_EN
    localparam int EE = 1;
`else
    localparam int EE = 0;
`endif

    logic clk;
    logic rst_n;
    logic busy;
    int   checks   = 0;
    int   failures = 0;

    lsl_iterative_if #(.WIDTH(WIDTH)) bus ();

    lsl_iterative #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain logical left shift truncated to WIDTH bits
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int s);
        logic [15:0] r;
        r = d << s;
        return r;
    endfunction

    // Reference latency in edges from accept to result
    function automatic int ref_latency(input int s);
`ifdef LSL_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int b = 0; b < SHW; b++) if (s[b]) m = b + 1;
        return (m < 1) ? 1 : m;
`else
        return SHW;
`endif
    endfunction

    // Model state
    int          edge_count = 0;
    bit          pending    = 1'b0;
    logic [15:0] exp_data   = '0;
    int          due_edge   = 0;
    logic        exp_valid;

    always @(posedge clk) edge_count <= edge_count + 1;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
            check("rst_in_ready",  32'(bus.in_ready),  32'd1);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_busy",      32'(busy),          32'd0);
            check("rst_out_data",  32'(bus.out_data),  32'd0);
        end else begin
            exp_valid = pending && (edge_count >= due_edge);
            check("in_ready",  32'(bus.in_ready),  32'(!pending));
            check("busy",      32'(busy),          32'(pending));
            check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid) check("out_data", 32'(bus.out_data), 32'(exp_data));
            if (exp_valid && bus.out_ready) begin
                pending = 1'b0;
            end else if (!pending && bus.in_valid) begin
                pending  = 1'b1;
                exp_data = ref_shift(bus.in_data, int'(bus.in_shamt));
                due_edge = edge_count + 1 + ref_latency(int'(bus.in_shamt));
            end
        end
    end

    // Issue one operand, wait for the result, check literal data and latency.
    // Returns on the falling edge where out_valid is first seen.
    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] s,
                          input logic [15:0] lit, input int lit_lat);
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus.in_ready) seen = 1'b1;
        end
        check({tag, "_accept"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        check({tag, "_seen"},    32'(seen),         32'd1);
        check({tag, "_latency"}, 32'(lat),          32'(lit_lat));
        check({tag, "_data"},    32'(bus.out_data), 32'(lit));
    endtask

    logic [15:0] got[$];
    int          prod_i;
    int          prod_guard;
    int          cons_guard;
    int          stale;
    bit          seen_v;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("init_in_ready",  32'(bus.in_ready),  32'd1);
        check("init_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic shift and single-cycle result pulse
        run_op("t1", 16'h000F, 4'd4, 16'h00F0, EE ? 3 : 4);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_valid_pulse", 32'(bus.out_valid), 32'd0);
        check("t1_ready_back",  32'(bus.in_ready),  32'd1);

        // Boundary shift amounts
        run_op("max", 16'hFFFF, 4'd15, 16'h8000, 4);
        run_op("zero", 16'h1234, 4'd0, 16'h1234, EE ? 1 : 4);

        // Backpressure: hold result, ignore new operand until drained
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_op("bp", 16'h00FF, 4'd2, 16'h03FC, EE ? 2 : 4);
        @(posedge clk); #1;
        bus.in_data  = 16'hAAAA;
        bus.in_shamt = 4'd0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(bus.out_valid), 32'd1);
            check("bp_data_held",  32'(bus.out_data),  32'h03FC);
            check("bp_in_ready",   32'(bus.in_ready),  32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        seen_v = 1'b0;
        for (int k = 0; k < 50 && !seen_v; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen_v = 1'b1;
        end
        check("bp_next_seen", 32'(seen_v),       32'd1);
        check("bp_next_data", 32'(bus.out_data), 32'hAAAA);

        // Reset two edges into SHIFT
        @(posedge clk); #1;
        bus.in_data  = 16'h5555;
        bus.in_shamt = 4'd3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("rm_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rm_out_valid", 32'(bus.out_valid), 32'd0);
        check("rm_busy",      32'(busy),          32'd0);
        check("rm_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("rm_no_stale", 32'(stale), 32'd0);
        run_op("rm_fresh", 16'h0001, 4'd3, 16'h0008, EE ? 2 : 4);

        // Latency profile of the early-exit option
        run_op("ee1", 16'h0001, 4'd1, 16'h0002, EE ? 1 : 4);
        run_op("ee5", 16'h0001, 4'd5, 16'h0020, EE ? 3 : 4);
        run_op("ee8", 16'h0001, 4'd8, 16'h0100, 4);

        // Back-to-back sweep with random result backpressure
        @(posedge clk); #1;
        got.delete();
        prod_i     = 0;
        prod_guard = 0;
        cons_guard = 0;
        bus.in_data  = 16'h8421;
        bus.in_shamt = 4'd0;
        bus.in_valid = 1'b1;
        fork
            begin
                while (prod_i < 16 && prod_guard < 2000) begin
                    @(negedge clk);
                    prod_guard++;
                    if (bus.in_ready) begin
                        @(posedge clk); #1;
                        prod_i++;
                        if (prod_i < 16) bus.in_shamt = 4'(prod_i);
                        else bus.in_valid = 1'b0;
                    end
                end
                bus.in_valid = 1'b0;
            end
            begin
                while (got.size() < 16 && cons_guard < 2000) begin
                    @(negedge clk);
                    cons_guard++;
                    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
                    @(posedge clk); #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        check("sweep_count", 32'(got.size()), 32'd16);
        if (got.size() == 16) begin
            for (int k = 0; k < 16; k++) check($sformatf("sweep_%0d", k), 32'(got[k]), 32'(ref_shift(16'h8421, k)));
            check("sweep_lit4",  32'(got[4]),  32'h4210);
            check("sweep_lit15", 32'(got[15]), 32'h8000);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
